// File: rtl/bin_to_bcd.sv
// Sequential double-dabble binary to 8-digit BCD converter.
// Digit outputs carry an optional leading-zero blanking mask.
module bin_to_bcd #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  input  logic             blank_lz,
  output logic             busy,
  output logic             done,
  output logic [3:0]       d1,
  output logic [3:0]       d2,
  output logic [3:0]       d3,
  output logic [3:0]       d4,
  output logic [3:0]       d5,
  output logic [3:0]       d6,
  output logic [3:0]       d7,
  output logic [3:0]       d8,
  output logic [7:0]       digitos
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             blank_q, blank_d;
  logic [31:0]      scr_q, scr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [31:0]      dig_q, dig_d;
  logic [7:0]       mask_q, mask_d;

  logic [31:0]      adj;
  logic [31:0]      shifted;

  // Bit k lights once nibble k or any higher nibble is nonzero.
  function automatic logic [7:0] lz_mask(
    input logic [31:0] v,
    input logic        en
  );
    logic [7:0] m;
    logic       seen;
    m    = 8'h00;
    seen = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (v[4*k +: 4] != 4'd0) seen = 1'b1;
      m[k] = seen;
    end
    m[0] = 1'b1;
    return en ? m : 8'hFF;
  endfunction

  always_comb begin
    adj = scr_q;
    for (int i = 0; i < 8; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
    shifted = {adj[30:0], bin_q[WIDTH-1]};
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    blank_d = blank_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    mask_d  = mask_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = bin;
          blank_d = blank_lz;
          scr_d   = 32'd0;
          cnt_d   = CW'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        scr_d = shifted;
        bin_d = bin_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          dig_d   = shifted;
          mask_d  = lz_mask(shifted, blank_q);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      blank_q <= 1'b0;
      scr_q   <= 32'd0;
      cnt_q   <= '0;
      dig_q   <= 32'd0;
      mask_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      blank_q <= blank_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      mask_q  <= mask_d;
    end
  end

  assign busy    = (state_q == SHIFT);
  assign done    = (state_q == DONE);
  assign d1      = dig_q[31:28];
  assign d2      = dig_q[27:24];
  assign d3      = dig_q[23:20];
  assign d4      = dig_q[19:16];
  assign d5      = dig_q[15:12];
  assign d6      = dig_q[11:8];
  assign d7      = dig_q[7:4];
  assign d8      = dig_q[3:0];
  assign digitos = mask_q;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Randomized self-checking bench for bin_to_bcd (WIDTH=16 and 26).
// Expected digits come from decimal arithmetic on the input value.
module tb_bin_to_bcd;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] bin;
  logic        blank_lz;
  logic        busy, done;
  logic [3:0]  d1, d2, d3, d4, d5, d6, d7, d8;
  logic [7:0]  digitos;

  logic        start26;
  logic [25:0] bin26;
  logic        blank26;
  logic        busy26, done26;
  logic [3:0]  e1, e2, e3, e4, e5, e6, e7, e8;
  logic [7:0]  digitos26;

  int tests_run = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bin_to_bcd #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .bin(bin),
    .blank_lz(blank_lz), .busy(busy), .done(done),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4),
    .d5(d5), .d6(d6), .d7(d7), .d8(d8),
    .digitos(digitos)
  );

  bin_to_bcd #(.WIDTH(26)) dut26 (
    .clk(clk), .reset(reset), .start(start26), .bin(bin26),
    .blank_lz(blank26), .busy(busy26), .done(done26),
    .d1(e1), .d2(e2), .d3(e3), .d4(e4),
    .d5(e5), .d6(e6), .d7(e7), .d8(e8),
    .digitos(digitos26)
  );

  wire [31:0] got16 = {d1, d2, d3, d4, d5, d6, d7, d8};
  wire [31:0] got26 = {e1, e2, e3, e4, e5, e6, e7, e8};

  function automatic logic [31:0] ref_bcd(input longint v);
    logic [31:0] r;
    longint      t;
    r = 32'd0;
    t = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] ref_mask(input longint v, input logic bl);
    logic [7:0] m;
    longint     p;
    if (!bl) return 8'hFF;
    m = 8'h00;
    p = 1;
    for (int k = 0; k < 8; k++) begin
      m[k] = (k == 0) || (v >= p);
      p = p * 10;
    end
    return m;
  endfunction

  task automatic run16(input logic [15:0] v, input logic bl,
                       output int lat, output int bcnt);
    @(negedge clk);
    bin = v; blank_lz = bl; start = 1'b1;
    lat = -1; bcnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      bin = 16'($urandom);
      blank_lz = ~bl;
      if (busy) bcnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b1; bin = 16'd99; blank_lz = 1'b0;
    start26 = 1'b0; bin26 = '0; blank26 = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy, done, got16, digitos} !== 42'd0) begin
      fails++;
      $display("FAIL reset_state busy=%b done=%b dig=%h mask=%h want 0",
               busy, done, got16, digitos);
    end
    tests_run++;
    if ({busy26, done26, got26, digitos26} !== 42'd0) begin
      fails++;
      $display("FAIL reset_state26 dig=%h mask=%h want 0", got26, digitos26);
    end
    start = 1'b0; reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_wins busy=%b want 0", busy);
    end
  endtask

  task automatic test_directed;
    int lat, bc;
    run16(16'd0, 1'b1, lat, bc);
    tests_run++;
    if (lat !== 17 || bc !== 16) begin
      fails++;
      $display("FAIL zero_latency lat=%0d busy=%0d want 17/16", lat, bc);
    end
    tests_run++;
    if (got16 !== 32'h0 || digitos !== 8'h01) begin
      fails++;
      $display("FAIL zero_value dig=%h mask=%h want 0/01", got16, digitos);
    end
    run16(16'd65535, 1'b1, lat, bc);
    tests_run++;
    if (got16 !== 32'h00065535 || digitos !== 8'h1F || lat !== 17) begin
      fails++;
      $display("FAIL max16 dig=%h mask=%h lat=%0d want 00065535/1F/17",
               got16, digitos, lat);
    end
    run16(16'd1234, 1'b0, lat, bc);
    tests_run++;
    if (got16 !== 32'h00001234 || digitos !== 8'hFF) begin
      fails++;
      $display("FAIL v1234 dig=%h mask=%h want 00001234/FF", got16, digitos);
    end
  endtask

  task automatic test_random;
    int lat, bc;
    logic [15:0] v;
    logic bl;
    for (int n = 0; n < 40; n++) begin
      v = 16'($urandom_range(0, 65535));
      if (n < 5) v = 16'(n * 10);
      bl = 1'($urandom);
      run16(v, bl, lat, bc);
      tests_run++;
      if (got16 !== ref_bcd(longint'(v)) ||
          digitos !== ref_mask(longint'(v), bl) || lat !== 17) begin
        fails++;
        $display("FAIL random v=%0d bl=%b dig=%h mask=%h lat=%0d want %h/%h/17",
                 v, bl, got16, digitos, lat,
                 ref_bcd(longint'(v)), ref_mask(longint'(v), bl));
      end
    end
  endtask

  task automatic test_ignore_and_hold;
    int lat;
    logic [31:0] keep;
    @(negedge clk);
    bin = 16'd4096; blank_lz = 1'b1; start = 1'b1;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = (k == 3);
      bin = 16'd9999;
      blank_lz = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
    tests_run++;
    if (lat !== 17 || got16 !== 32'h00004096 || digitos !== 8'h0F) begin
      fails++;
      $display("FAIL ignore_shift lat=%0d dig=%h mask=%h want 17/4096/0F",
               lat, got16, digitos);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL ignore_done busy=%b want 0", busy);
    end
    keep = got16;
    repeat (5) begin
      @(negedge clk);
      bin = 16'($urandom);
    end
    tests_run++;
    if (got16 !== 32'h00004096 || digitos !== 8'h0F || done !== 1'b0) begin
      fails++;
      $display("FAIL hold dig=%h mask=%h done=%b want %h/0F/0",
               got16, digitos, done, keep);
    end
  endtask

  task automatic test_back_to_back;
    int first, second, extra;
    @(negedge clk);
    bin = 16'd4321; blank_lz = 1'b0; start = 1'b1;
    first = -1; second = -1; extra = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done) begin
        if (first < 0) first = k;
        else begin
          second = k;
          start = 1'b0;
          break;
        end
      end
    end
    repeat (25) begin
      @(negedge clk);
      if (done) extra++;
    end
    tests_run++;
    if (first !== 17 || second - first !== 18 || extra !== 0) begin
      fails++;
      $display("FAIL back_to_back first=%0d gap=%0d extra=%0d want 17/18/0",
               first, second - first, extra);
    end
    tests_run++;
    if (got16 !== 32'h00004321 || digitos !== 8'hFF) begin
      fails++;
      $display("FAIL b2b_value dig=%h mask=%h want 00004321/FF", got16, digitos);
    end
  endtask

  task automatic test_reset_abort;
    int dones, lat, bc;
    @(negedge clk);
    bin = 16'd40000; blank_lz = 1'b1; start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    tests_run++;
    if (busy !== 1'b0 || got16 !== 32'h0 || digitos !== 8'h00) begin
      fails++;
      $display("FAIL abort_state busy=%b dig=%h mask=%h want 0/0/00",
               busy, got16, digitos);
    end
    repeat (20) begin
      @(negedge clk);
      if (done) dones++;
    end
    tests_run++;
    if (dones !== 0 || got16 !== 32'h0) begin
      fails++;
      $display("FAIL abort_nodone dones=%0d dig=%h want 0/0", dones, got16);
    end
    run16(16'd7, 1'b1, lat, bc);
    tests_run++;
    if (got16 !== 32'h7 || digitos !== 8'h01 || lat !== 17) begin
      fails++;
      $display("FAIL after_abort dig=%h mask=%h lat=%0d want 7/01/17",
               got16, digitos, lat);
    end
  endtask

  task automatic test_width26;
    int lat;
    logic [25:0] v;
    for (int n = 0; n < 6; n++) begin
      v = (n == 0) ? 26'd67108863 : 26'($urandom);
      @(negedge clk);
      bin26 = v; blank26 = (n == 0) ? 1'b0 : 1'($urandom); start26 = 1'b1;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        start26 = 1'b0;
        if (done26) begin
          lat = k;
          break;
        end
      end
      tests_run++;
      if (lat !== 27 || got26 !== ref_bcd(longint'(v)) ||
          digitos26 !== ref_mask(longint'(v), blank26)) begin
        fails++;
        $display("FAIL width26 v=%0d dig=%h mask=%h lat=%0d want %h/%h/27",
                 v, got26, digitos26, lat, ref_bcd(longint'(v)),
                 ref_mask(longint'(v), blank26));
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_ignore_and_hold;
    test_back_to_back;
    test_reset_abort;
    test_width26;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
